hazard_ctrl: RTL and testbench

// - Hazard/sequencing controller for the 5-stage pipeline: drives stall/flush of F/D, D/E, E/M, M/W registers
//   and forwarding selects into the E-stage ALU operand muxes.
// - Resolves RAW forwarding, load-use stalls, taken branch/jump flushes, and multi-cycle data-memory waits
//   (FSM with timeout). Sits beside the pipeline registers; all pipeline regs consume its stall/flush lines.

---
 rtl/hazard_ctrl_if.sv | 44 ++++
 rtl/hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline and hazard_ctrl.
// master: pipeline side (drives hazard inputs, consumes stall/flush/forward).
// slave : hazard_ctrl side.
interface hazard_ctrl_if;
   logic [4:0]  rs1_d;
   logic [4:0]  rs2_d;
   logic [4:0]  rs1_e;
   logic [4:0]  rs2_e;
   logic [4:0]  rd_e;
   logic [1:0]  result_src_e;
   logic        pc_src_e;
   logic [4:0]  rd_m;
   logic [4:0]  rd_w;
   logic        reg_write_m;
   logic        reg_write_w;
   logic        mem_req_m;
   logic        mem_ready;
   logic [1:0]  forward_a_e;
   logic [1:0]  forward_b_e;
   logic        stall_f;
   logic        stall_d;
   logic        stall_e;
   logic        stall_m;
   logic        flush_d;
   logic        flush_e;
   logic        flush_w;
   logic        mem_err;
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;

   modport master (
      output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e, pc_src_e,
             rd_m, rd_w, reg_write_m, reg_write_w, mem_req_m, mem_ready,
      input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
             flush_d, flush_e, flush_w, mem_err, stall_cycles, flush_count
   );

   modport slave (
      input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e, pc_src_e,
             rd_m, rd_w, reg_write_m, reg_write_w, mem_req_m, mem_ready,
      output forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
             flush_d, flush_e, flush_w, mem_err, stall_cycles, flush_count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: operand forwarding,
// load-use stalls, branch/jump flushes and data-memory wait handling with a
// timeout that drops the stuck access and pulses mem_err.
// Optional feature: define HAZARD_PERF_CNT_EN to build the 32-bit stall/flush
// performance counters; otherwise both counter outputs are tied to zero.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   hazard_ctrl_if.slave  hif
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      MEM_ERR  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic [1:0] fwd_a, fwd_b;
   logic       lw_stall, mem_hold;
   logic       stall_f, stall_d, stall_e, stall_m;
   logic       flush_d, flush_e, flush_w, mem_err;

   // x0 is never forwarded; the younger M-stage result beats the W-stage one.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic       wr_m, input logic [4:0] rd_m,
                                          input logic       wr_w, input logic [4:0] rd_w);
      if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
         return 2'b10;
      else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   // State register and memory-wait counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next-state logic and combinational stall/flush/forward outputs.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      fwd_a      = 2'b00;
      fwd_b      = 2'b00;
      stall_f    = 1'b0;
      stall_d    = 1'b0;
      stall_e    = 1'b0;
      stall_m    = 1'b0;
      flush_d    = 1'b0;
      flush_e    = 1'b0;
      flush_w    = 1'b0;
      mem_err    = 1'b0;

      lw_stall = (hif.result_src_e == 2'b01) && (hif.rd_e != 5'd0) &&
                 ((hif.rd_e == hif.rs1_d) || (hif.rd_e == hif.rs2_d));
      mem_hold = hif.mem_req_m && !hif.mem_ready;

      if (!rst) begin
         fwd_a = fwd_sel(hif.rs1_e, hif.reg_write_m, hif.rd_m, hif.reg_write_w, hif.rd_w);
         fwd_b = fwd_sel(hif.rs2_e, hif.reg_write_m, hif.rd_m, hif.reg_write_w, hif.rd_w);

         if (state_q == MEM_ERR) begin
            // M advances so the stuck access is dropped; older stages still hold.
            mem_err    = 1'b1;
            flush_w    = 1'b1;
            stall_f    = 1'b1;
            stall_d    = 1'b1;
            stall_e    = 1'b1;
            state_d    = RUN;
            wait_cnt_d = '0;
         end else begin
            if (mem_hold) begin
               // Freeze the whole front; branch and load-use handling wait.
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               stall_m = 1'b1;
               flush_w = 1'b1;
            end else begin
               stall_f = lw_stall;
               stall_d = lw_stall;
               flush_d = hif.pc_src_e;
               flush_e = lw_stall | hif.pc_src_e;
            end

            if (state_q == RUN) begin
               if (mem_hold) begin
                  state_d    = MEM_WAIT;
                  wait_cnt_d = CNT_ONE;
               end
            end else begin
               // Ready on the timeout cycle wins over the abort.
               if (hif.mem_ready) begin
                  state_d    = RUN;
                  wait_cnt_d = '0;
               end else if (wait_cnt_q == CNT_LAST) begin
                  state_d = MEM_ERR;
               end else begin
                  wait_cnt_d = wait_cnt_q + CNT_ONE;
               end
            end
         end
      end
   end

   assign hif.forward_a_e = fwd_a;
   assign hif.forward_b_e = fwd_b;
   assign hif.stall_f     = stall_f;
   assign hif.stall_d     = stall_d;
   assign hif.stall_e     = stall_e;
   assign hif.stall_m     = stall_m;
   assign hif.flush_d     = flush_d;
   assign hif.flush_e     = flush_e;
   assign hif.flush_w     = flush_w;
   assign hif.mem_err     = mem_err;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   // Free-running performance counters, wrapping at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_f)
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (flush_d | flush_e)
            flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign hif.stall_cycles = stall_cnt_q;
   assign hif.flush_count  = flush_cnt_q;
`else
   assign hif.stall_cycles = '0;
   assign hif.flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MEM_TIMEOUT = 4).
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic rst;

   hazard_ctrl_if hif ();

   hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .hif (hif)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [11:0] v;
   } exp_t;

   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_stall_cnt = 0;
   logic [31:0] exp_flush_cnt = 0;

   // Output vector: {fwd_a[1:0], fwd_b[1:0], sf, sd, se, sm, fd, fe, fw, merr}
   function automatic logic [11:0] vec(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic sf, input logic sd, input logic se,
                                       input logic sm, input logic fd, input logic fe,
                                       input logic fw, input logic me);
      return {fa, fb, sf, sd, se, sm, fd, fe, fw, me};
   endfunction

   localparam logic [11:0] V_IDLE = 12'b00_00_0000_0000;
   localparam logic [11:0] V_HOLD = 12'b00_00_1111_0010;
   localparam logic [11:0] V_ERR  = 12'b00_00_1110_0011;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      hif.rs1_d = 5'd0; hif.rs2_d = 5'd0; hif.rs1_e = 5'd0; hif.rs2_e = 5'd0;
      hif.rd_e = 5'd0; hif.result_src_e = 2'b00; hif.pc_src_e = 1'b0;
      hif.rd_m = 5'd0; hif.rd_w = 5'd0; hif.reg_write_m = 1'b0; hif.reg_write_w = 1'b0;
      hif.mem_req_m = 1'b0; hif.mem_ready = 1'b0;
   endtask

   // Push expectation for this cycle, compare at the falling edge, advance.
   task automatic step(input string tag, input logic [11:0] expv);
      exp_t e, got;
      logic [11:0] obs;
      e.tag = tag;
      e.v   = expv;
      sb_q.push_back(e);
      @(negedge clk);
      got = sb_q.pop_front();
      obs = {hif.forward_a_e, hif.forward_b_e, hif.stall_f, hif.stall_d, hif.stall_e,
             hif.stall_m, hif.flush_d, hif.flush_e, hif.flush_w, hif.mem_err};
      check_val(got.tag, {20'd0, obs}, {20'd0, got.v});
      if (rst) begin
         exp_stall_cnt = 0;
         exp_flush_cnt = 0;
      end
`ifdef HAZARD_PERF_CNT_EN
      check_val({got.tag, "_scnt"}, hif.stall_cycles, exp_stall_cnt);
      check_val({got.tag, "_fcnt"}, hif.flush_count, exp_flush_cnt);
      if (!rst) begin
         exp_stall_cnt = exp_stall_cnt + {31'd0, got.v[7]};
         exp_flush_cnt = exp_flush_cnt + {31'd0, got.v[3] | got.v[2]};
      end
`else
      check_val({got.tag, "_scnt"}, hif.stall_cycles, 32'd0);
      check_val({got.tag, "_fcnt"}, hif.flush_count, 32'd0);
`endif
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      clear_inputs();
      // Hazard-looking inputs during reset must not leak to outputs.
      hif.rd_m = 5'd5; hif.reg_write_m = 1'b1; hif.rs1_e = 5'd5;
      hif.result_src_e = 2'b01; hif.rd_e = 5'd7; hif.rs2_d = 5'd7; hif.pc_src_e = 1'b1;
      hif.mem_req_m = 1'b1;
      step("rst_a", V_IDLE);
      step("rst_b", V_IDLE);
      rst = 1'b0;
      clear_inputs();
      step("idle", V_IDLE);

      // Forwarding
      hif.rd_m = 5'd5; hif.reg_write_m = 1'b1; hif.rs1_e = 5'd5; hif.rs2_e = 5'd5;
      hif.rd_w = 5'd5; hif.reg_write_w = 1'b1;
      step("fwd_m_prio", vec(2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
      clear_inputs();
      hif.rd_w = 5'd3; hif.reg_write_w = 1'b1; hif.rs1_e = 5'd3; hif.rs2_e = 5'd4;
      hif.rd_m = 5'd3; hif.reg_write_m = 1'b0;
      step("fwd_w", vec(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      clear_inputs();
      hif.rd_m = 5'd0; hif.reg_write_m = 1'b1; hif.rs2_e = 5'd0; hif.rs1_e = 5'd0;
      hif.rd_w = 5'd0; hif.reg_write_w = 1'b1;
      step("fwd_x0", V_IDLE);
      clear_inputs();
      hif.rd_m = 5'd9; hif.reg_write_m = 1'b1; hif.rs2_e = 5'd9; hif.rs1_e = 5'd8;
      hif.rd_w = 5'd8; hif.reg_write_w = 1'b1;
      step("fwd_mix", vec(2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));

      // Load-use
      clear_inputs();
      hif.result_src_e = 2'b01; hif.rd_e = 5'd7; hif.rs2_d = 5'd7;
      step("lw_stall", vec(2'b00, 2'b00, 1, 1, 0, 0, 0, 1, 0, 0));
      clear_inputs();
      step("lw_release", V_IDLE);
      hif.result_src_e = 2'b01; hif.rd_e = 5'd0; hif.rs1_d = 5'd0;
      step("lw_x0", V_IDLE);
      hif.result_src_e = 2'b10; hif.rd_e = 5'd7; hif.rs1_d = 5'd7;
      step("not_load", V_IDLE);

      // Branch flush
      clear_inputs();
      hif.pc_src_e = 1'b1;
      step("branch", vec(2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0));
      hif.result_src_e = 2'b01; hif.rd_e = 5'd6; hif.rs1_d = 5'd6;
      step("branch_lw", vec(2'b00, 2'b00, 1, 1, 0, 0, 1, 1, 0, 0));

      // Memory wait, ready after 3 cycles; branch/load-use deferred meanwhile
      clear_inputs();
      hif.mem_req_m = 1'b1;
      step("mw_1", V_HOLD);
      hif.pc_src_e = 1'b1; hif.result_src_e = 2'b01; hif.rd_e = 5'd6; hif.rs1_d = 5'd6;
      step("mw_2_defer", V_HOLD);
      hif.pc_src_e = 1'b0; hif.result_src_e = 2'b00;
      step("mw_3", V_HOLD);
      hif.mem_ready = 1'b1;
      step("mw_ready", V_IDLE);
      clear_inputs();
      step("mw_after", V_IDLE);

      // Timeout: 4 hold cycles, mem_err in the 5th, RUN in the 6th
      hif.mem_req_m = 1'b1;
      step("to_1", V_HOLD);
      step("to_2", V_HOLD);
      step("to_3", V_HOLD);
      step("to_4", V_HOLD);
      step("to_err", V_ERR);
      clear_inputs();
      step("to_run", V_IDLE);

      // Ready on the timeout cycle wins
      hif.mem_req_m = 1'b1;
      step("rw_1", V_HOLD);
      step("rw_2", V_HOLD);
      step("rw_3", V_HOLD);
      hif.mem_ready = 1'b1;
      step("rw_ready", V_IDLE);
      clear_inputs();
      step("rw_no_err", V_IDLE);

      // Reset mid-wait: straight back to RUN, no error pulse, counter restarted
      hif.mem_req_m = 1'b1;
      step("rm_1", V_HOLD);
      step("rm_2", V_HOLD);
      rst = 1'b1;
      step("rm_rst", V_IDLE);
      rst = 1'b0;
      clear_inputs();
      step("rm_no_err", V_IDLE);
      hif.mem_req_m = 1'b1;
      step("rm_h1", V_HOLD);
      step("rm_h2", V_HOLD);
      step("rm_h3", V_HOLD);
      step("rm_h4", V_HOLD);
      step("rm_err", V_ERR);
      clear_inputs();
      step("rm_run", V_IDLE);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
